// File: rtl/display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter_if
//  Description : Source requests, display values and display-drive outputs
//                shared between the display arbiter and its surroundings.
//                Optional macro DISP_LAMPTEST_EN adds the lamp_test signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface display_arbiter_if;
   logic       req_alarm;
   logic       req_edit;
   logic       req_run;
   logic       edit_field;
   logic [7:0] val_temp;
   logic [7:0] val_time;
   logic [7:0] val_set_temp;
   logic [7:0] val_set_time;
   logic [7:0] err_code;
`ifdef DISP_LAMPTEST_EN
   logic       lamp_test;
`endif
   logic       scan_tick;
   logic [1:0] page;
   logic [7:0] left_val;
   logic [7:0] right_val;
   logic       blank_left;
   logic       blank_right;
   logic       page_chg;

   // Side that supplies requests and values and consumes the display drive
   modport master (
      output req_alarm, req_edit, req_run, edit_field,
      output val_temp, val_time, val_set_temp, val_set_time, err_code,
`ifdef DISP_LAMPTEST_EN
      output lamp_test,
`endif
      input  scan_tick, page, left_val, right_val,
      input  blank_left, blank_right, page_chg
   );

   // The arbiter itself
   modport slave (
      input  req_alarm, req_edit, req_run, edit_field,
      input  val_temp, val_time, val_set_temp, val_set_time, err_code,
`ifdef DISP_LAMPTEST_EN
      input  lamp_test,
`endif
      output scan_tick, page, left_val, right_val,
      output blank_left, blank_right, page_chg
   );
endinterface
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Shares the 8-digit "c=xx t=yy" display between the idle,
//                run, setpoint-edit and alarm pages. Generates the scan
//                strobe, arbitrates pages by priority with a minimum dwell,
//                blinks the edited half and saturates values to 0..99.
//                Optional macro DISP_LAMPTEST_EN adds a lamp-test override.
//  Revision    : 1.0  initial release
// ============================================================================
module display_arbiter #(
   parameter int CLK_DIV     = 1000,
   parameter int DWELL_TICKS = 512,
   parameter int BLINK_TICKS = 256
) (
   input  wire logic          clk,
   input  wire logic          rst,
   display_arbiter_if.slave   bus
);

   localparam int c_PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_DWELL_W = $clog2(DWELL_TICKS + 1);
   localparam int c_BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX  = c_PRESC_W'(CLK_DIV - 1);
   localparam logic [c_DWELL_W-1:0] c_DWELL_INIT = c_DWELL_W'(DWELL_TICKS - 1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_MAX  = c_BLINK_W'(BLINK_TICKS - 1);
   localparam logic [7:0]           c_VAL_MAX    = 8'd99;

   typedef enum logic [1:0] {
      PG_IDLE  = 2'd0,
      PG_RUN   = 2'd1,
      PG_EDIT  = 2'd2,
      PG_ALARM = 2'd3
   } page_t;

   logic [c_PRESC_W-1:0] r_presc;
   logic                 r_scan_tick;
   page_t                r_page;
   logic [c_DWELL_W-1:0] r_dwell;
   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic                 r_blink_phase;
   logic                 r_page_chg;
   logic [7:0]           r_left;
   logic [7:0]           r_right;
   logic                 r_blank_left;
   logic                 r_blank_right;

   page_t                w_target;
   logic                 w_cur_req;
   logic                 w_switch;
   logic [7:0]           w_left;
   logic [7:0]           w_right;
   logic                 w_blank_left;
   logic                 w_blank_right;

   // Two-digit display halves cannot show more than 99
   function automatic logic [7:0] sat99(input logic [7:0] v);
      return (v > c_VAL_MAX) ? c_VAL_MAX : v;
   endfunction

   // Prescaler and registered scan strobe, one pulse per CLK_DIV clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc     <= '0;
         r_scan_tick <= 1'b0;
      end else begin
         r_scan_tick <= (r_presc == c_PRESC_MAX);
         r_presc     <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + c_PRESC_W'(1);
      end
   end

   // Priority target and switch decision; IDLE has no request of its own,
   // so leaving it always honours the dwell time
   always_comb begin
      w_target  = PG_IDLE;
      w_cur_req = 1'b1;
      if (bus.req_alarm)     w_target = PG_ALARM;
      else if (bus.req_edit) w_target = PG_EDIT;
      else if (bus.req_run)  w_target = PG_RUN;
      case (r_page)
         PG_RUN:   w_cur_req = bus.req_run;
         PG_EDIT:  w_cur_req = bus.req_edit;
         PG_ALARM: w_cur_req = bus.req_alarm;
         default:  w_cur_req = 1'b1;
      endcase
      w_switch = (w_target != r_page) &&
                 ((w_target == PG_ALARM) || !w_cur_req || (r_dwell == '0));
   end

   // Page state machine with dwell timer and edit-mode blink timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_page        <= PG_IDLE;
         r_dwell       <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_page_chg    <= 1'b0;
      end else begin
         r_page_chg <= w_switch;
         if (w_switch) begin
            r_page        <= w_target;
            r_dwell       <= c_DWELL_INIT;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
         end else begin
            if (r_scan_tick && (r_dwell != '0))
               r_dwell <= r_dwell - c_DWELL_W'(1);
            if (r_scan_tick && (r_page == PG_EDIT)) begin
               if (r_blink_cnt == c_BLINK_MAX) begin
                  r_blink_cnt   <= '0;
                  r_blink_phase <= ~r_blink_phase;
               end else begin
                  r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
               end
            end
         end
      end
   end

   // Content selection from the page in effect this clock
   always_comb begin
      w_left        = sat99(bus.val_temp);
      w_right       = sat99(bus.val_set_time);
      w_blank_left  = 1'b0;
      w_blank_right = 1'b0;
      case (r_page)
         PG_RUN: begin
            w_right = sat99(bus.val_time);
         end
         PG_EDIT: begin
            w_left        = sat99(bus.val_set_temp);
            w_right       = sat99(bus.val_set_time);
            w_blank_left  = r_blink_phase && !bus.edit_field;
            w_blank_right = r_blink_phase &&  bus.edit_field;
         end
         PG_ALARM: begin
            w_left        = sat99(bus.err_code);
            w_right       = 8'd0;
            w_blank_right = 1'b1;
         end
         default: begin
            w_left = sat99(bus.val_temp);
         end
      endcase
`ifdef DISP_LAMPTEST_EN
      // Lamp test lights every segment; arbitration keeps running underneath
      if (bus.lamp_test) begin
         w_left        = 8'd88;
         w_right       = 8'd88;
         w_blank_left  = 1'b0;
         w_blank_right = 1'b0;
      end
`endif
   end

   // Output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_left        <= 8'd0;
         r_right       <= 8'd0;
         r_blank_left  <= 1'b0;
         r_blank_right <= 1'b0;
      end else begin
         r_left        <= w_left;
         r_right       <= w_right;
         r_blank_left  <= w_blank_left;
         r_blank_right <= w_blank_right;
      end
   end

   assign bus.scan_tick   = r_scan_tick;
   assign bus.page        = r_page;
   assign bus.left_val    = r_left;
   assign bus.right_val   = r_right;
   assign bus.blank_left  = r_blank_left;
   assign bus.blank_right = r_blank_right;
   assign bus.page_chg    = r_page_chg;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Self-checking bench for display_arbiter with CLK_DIV=4,
//                DWELL_TICKS=3, BLINK_TICKS=2. Output vector per clock is
//                {page, left, right, blank_left, blank_right, page_chg,
//                scan_tick}. Honours DISP_LAMPTEST_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_arbiter;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   n_fail;
   logic [21:0] q[$];

   display_arbiter_if bus ();

   display_arbiter #(
      .CLK_DIV     (4),
      .DWELL_TICKS (3),
      .BLINK_TICKS (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [21:0] obs_vec();
      return {bus.page, bus.left_val, bus.right_val, bus.blank_left,
              bus.blank_right, bus.page_chg, bus.scan_tick};
   endfunction

   // Expected vector for clock c; the strobe is high after edges 4, 8, 12...
   function automatic logic [21:0] exp_vec(input logic [1:0] pg, input logic [7:0] l,
                                           input logic [7:0] r, input logic bl,
                                           input logic br, input logic pc, input int c);
      return {pg, l, r, bl, br, pc, (c % 4 == 0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      logic [21:0] o;
      rst = 1'b1;
      bus.req_alarm = 0; bus.req_edit = 0; bus.req_run = 0; bus.edit_field = 0;
      bus.val_temp = 8'd25; bus.val_time = 8'd10; bus.val_set_temp = 8'd70;
      bus.val_set_time = 8'd60; bus.err_code = 8'd7;
`ifdef DISP_LAMPTEST_EN
      bus.lamp_test = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      o = obs_vec();
      n_chk++;
      if (o !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_state got %h want %h", o, 22'h0);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_idle();
      logic [21:0] o, e;
      for (int c = 1; c <= 12; c++) begin
         q.push_back(exp_vec(2'd0, 8'd25, 8'd60, 1'b0, 1'b0, 1'b0, c));
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL idle c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
   endtask

   // RUN entry, saturation boundaries, then EDIT held off by dwell
   task automatic test_run_sat_dwell();
      logic [21:0] o, e;
      logic [7:0]  l, r;
      for (int c = 13; c <= 22; c++) begin
         case (c)
            13: bus.req_run = 1'b1;
            15: bus.val_temp = 8'd150;
            16: bus.val_temp = 8'd42;
            17: begin bus.req_edit = 1'b1; bus.val_temp = 8'd100; end
            18: bus.val_temp = 8'd99;
            19: bus.val_temp = 8'd42;
            default: ;
         endcase
         if (c <= 14)                 l = 8'd25;
         else if (c == 16 || c >= 19) l = 8'd42;
         else                         l = 8'd99;
         r = (c == 13) ? 8'd60 : 8'd10;
         q.push_back(exp_vec((c == 22) ? 2'd2 : 2'd1, l, r, 1'b0, 1'b0,
                             (c == 13 || c == 22), c));
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL run_dwell c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
   endtask

   task automatic test_edit_blink();
      logic [21:0] o, e;
      for (int c = 23; c <= 38; c++) begin
         if (c == 23) begin
            bus.edit_field   = 1'b1;
            bus.val_set_time = 8'd30;
         end
         q.push_back(exp_vec(2'd2, 8'd70, 8'd30, 1'b0, (c >= 30 && c <= 37), 1'b0, c));
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL edit_blink c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
   endtask

   // Alarm preempts, release returns to EDIT at once, re-alarm ignores dwell
   task automatic test_alarm();
      logic [21:0] o, e;
      for (int c = 39; c <= 45; c++) begin
         case (c)
            39: begin bus.req_alarm = 1'b1; bus.err_code = 8'd7; end
            42: bus.req_alarm = 1'b0;
            44: begin bus.req_alarm = 1'b1; bus.err_code = 8'd150; end
`ifdef DISP_LAMPTEST_EN
            45: bus.lamp_test = 1'b1;
`endif
            default: ;
         endcase
         case (c)
            39:      e = exp_vec(2'd3, 8'd70, 8'd30, 1'b0, 1'b0, 1'b1, c);
            40, 41:  e = exp_vec(2'd3, 8'd7,  8'd0,  1'b0, 1'b1, 1'b0, c);
            42:      e = exp_vec(2'd2, 8'd7,  8'd0,  1'b0, 1'b1, 1'b1, c);
            43:      e = exp_vec(2'd2, 8'd70, 8'd30, 1'b0, 1'b0, 1'b0, c);
            44:      e = exp_vec(2'd3, 8'd70, 8'd30, 1'b0, 1'b0, 1'b1, c);
`ifdef DISP_LAMPTEST_EN
            default: e = exp_vec(2'd3, 8'd88, 8'd88, 1'b0, 1'b0, 1'b0, c);
`else
            default: e = exp_vec(2'd3, 8'd99, 8'd0,  1'b0, 1'b1, 1'b0, c);
`endif
         endcase
         q.push_back(e);
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL alarm c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
   endtask

   // Back to EDIT, reach a blank phase, then reset asynchronously
   task automatic test_reset_mid();
      logic [21:0] o, e;
      for (int c = 46; c <= 54; c++) begin
         if (c == 46) begin
            bus.req_alarm = 1'b0;
`ifdef DISP_LAMPTEST_EN
            bus.lamp_test = 1'b0;
`endif
         end
         if (c == 46) e = exp_vec(2'd2, 8'd99, 8'd0, 1'b0, 1'b1, 1'b1, c);
         else         e = exp_vec(2'd2, 8'd70, 8'd30, 1'b0, (c == 54), 1'b0, c);
         q.push_back(e);
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL edit_pre_reset c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
      #2;
      rst = 1'b1;
      #1;
      o = obs_vec();
      n_chk++;
      if (o !== 22'h0) begin
         n_fail++;
         $display("FAIL async_reset got %h want %h", o, 22'h0);
      end else n_pass++;
      bus.req_edit = 1'b0; bus.req_run = 1'b0;
      @(posedge clk);
      #1;
      o = obs_vec();
      n_chk++;
      if (o !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_held got %h want %h", o, 22'h0);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 5; c++) begin
         q.push_back(exp_vec(2'd0, 8'd42, 8'd30, 1'b0, 1'b0, 1'b0, c));
         step();
         e = q.pop_front();
         o = obs_vec();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL post_reset c=%0d got %h want %h", c, o, e);
         end else n_pass++;
      end
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      n_fail = 0;
      cyc    = 0;
      test_reset();
      test_idle();
      test_run_sat_dwell();
      test_edit_blink();
      test_alarm();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
